// File: rtl/tl_memory_master_bridge_pkg.sv
// Shared definitions for the TL-UL master bridge and its slave-side peers.
// Contents:
//   mem_access_size_t  - core access size (BYTE/HALF/WORD), encoded as TL a_size
//   TL_* localparams   - bus widths and channel A/D opcode encodings
//   tl_size_to_mask    - byte-lane mask for an access of a given size/offset
//   tl_is_misaligned   - natural-alignment check for an access
package tl_memory_master_bridge_pkg;

   typedef enum logic [1:0] {
      MEM_BYTE = 2'd0,
      MEM_HALF = 2'd1,
      MEM_WORD = 2'd2
   } mem_access_size_t;

   localparam int TL_AW   = 32;   // address width
   localparam int TL_DW   = 32;   // data width
   localparam int TL_DBW  = 4;    // byte lanes
   localparam int TL_SZW  = 2;    // a_size / d_size width
   localparam int TL_SRCW = 4;    // source id width

   // Channel A opcodes
   localparam logic [2:0] TL_A_PUT_FULL_DATA = 3'd0;
   localparam logic [2:0] TL_A_GET           = 3'd4;

   // Channel D opcodes
   localparam logic [2:0] TL_D_ACCESS_ACK      = 3'd0;
   localparam logic [2:0] TL_D_ACCESS_ACK_DATA = 3'd1;

   // Lane mask of an access: 1, 2 or 4 contiguous lanes starting at addr_lo.
   // An unsupported size yields an empty mask.
   function automatic logic [3:0] tl_size_to_mask(input logic [1:0] size,
                                                   input logic [1:0] addr_lo);
      logic [3:0] base;
      case (size)
         2'd0:    base = 4'b0001;
         2'd1:    base = 4'b0011;
         2'd2:    base = 4'b1111;
         default: base = 4'b0000;
      endcase
      return base << addr_lo;
   endfunction

   // Accesses must be naturally aligned; the reserved size code is treated
   // as unusable so it never reaches the bus.
   function automatic logic tl_is_misaligned(input logic [1:0] size,
                                              input logic [1:0] addr_lo);
      logic bad;
      case (size)
         2'd0:    bad = 1'b0;
         2'd1:    bad = addr_lo[0];
         2'd2:    bad = |addr_lo;
         default: bad = 1'b1;
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/tl_memory_master_bridge_if.sv
// TL-UL channel A / channel D bundle between the bridge and the crossbar.
// Modports:
//   master_ul - drives a_* and d_ready; samples a_ready and d_*
//   slave_ul  - the mirror image, for the memory side / test models
interface tl_memory_master_bridge_if import tl_memory_master_bridge_pkg::*; ();

   // Channel A
   logic                a_valid;
   logic                a_ready;
   logic [2:0]          a_opcode;
   logic [2:0]          a_param;
   logic [TL_SZW-1:0]   a_size;
   logic [TL_SRCW-1:0]  a_source;
   logic [TL_AW-1:0]    a_address;
   logic [TL_DBW-1:0]   a_mask;
   logic [TL_DW-1:0]    a_data;

   // Channel D
   logic                d_valid;
   logic                d_ready;
   logic [2:0]          d_opcode;
   logic [TL_SRCW-1:0]  d_source;
   logic [TL_DW-1:0]    d_data;
   logic                d_error;

   modport master_ul (
      output a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data,
      input  a_ready,
      input  d_valid, d_opcode, d_source, d_data, d_error,
      output d_ready
   );

   modport slave_ul (
      input  a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data,
      output a_ready,
      output d_valid, d_opcode, d_source, d_data, d_error,
      input  d_ready
   );

endinterface

// File: rtl/tl_memory_master_bridge_lane_align.sv
// tl_lane_align: purely combinational byte-lane steering for one access.
// Ports:
//   size_i, addr_lo_i - access size and byte offset within the word
//   wdata_i           - right-justified store data from the core
//   d_data_i          - raw channel D read data
//   a_mask_o          - channel A lane mask
//   a_data_o          - store data moved onto its lanes
//   rdata_o           - read data right-justified and zero-extended
module tl_lane_align import tl_memory_master_bridge_pkg::*; (
   input  mem_access_size_t    size_i,
   input  logic [1:0]          addr_lo_i,
   input  logic [TL_DW-1:0]    wdata_i,
   input  logic [TL_DW-1:0]    d_data_i,
   output logic [TL_DBW-1:0]   a_mask_o,
   output logic [TL_DW-1:0]    a_data_o,
   output logic [TL_DW-1:0]    rdata_o
);

   logic [4:0]          shamt;
   logic [TL_DBW-1:0]   keep_lanes;
   logic [TL_DW-1:0]    keep_bits;
   logic [TL_DW-1:0]    rd_shifted;

   assign shamt      = {addr_lo_i, 3'b000};
   assign a_mask_o   = tl_size_to_mask(size_i, addr_lo_i);
   assign a_data_o   = wdata_i << shamt;
   assign rd_shifted = d_data_i >> shamt;

   // After right-justifying, the lanes to keep are the ones an access of
   // this size would cover at offset 0.
   assign keep_lanes = tl_size_to_mask(size_i, 2'b00);

   generate
      for (genvar gi = 0; gi < TL_DBW; gi++) begin : g_keep
         assign keep_bits[8*gi +: 8] = {8{keep_lanes[gi]}};
      end
   endgenerate

   assign rdata_o = rd_shifted & keep_bits;

endmodule

// File: rtl/tl_memory_master_bridge.sv
// tl_memory_master_bridge: turns the core's single-outstanding load/store
// request into a TL-UL Get / PutFullData and returns the AccessAck(Data)
// result (or an error) to the core.
// Ports:
//   clk_i, reset_ni                      - clock, async active-low reset
//   req_valid_i/req_ready_o              - core request handshake
//   req_we_i/req_addr_i/req_size_i/req_wdata_i - request payload
//   resp_valid_o/resp_ready_i            - core response handshake
//   resp_rdata_o/resp_error_o            - response payload
//   tilelink                             - TL-UL master side (channels A/D)
// Parameters:
//   SOURCE_ID - a_source value, also the only accepted d_source
//   TIMEOUT   - WAIT_D cycles before giving up with an error (0 = never)
module tl_memory_master_bridge import tl_memory_master_bridge_pkg::*; #(
   parameter int unsigned SOURCE_ID = 0,
   parameter int unsigned TIMEOUT   = 255
) (
   input  logic                 clk_i,
   input  logic                 reset_ni,

   input  logic                 req_valid_i,
   output logic                 req_ready_o,
   input  logic                 req_we_i,
   input  logic [TL_AW-1:0]     req_addr_i,
   input  mem_access_size_t     req_size_i,
   input  logic [TL_DW-1:0]     req_wdata_i,

   output logic                 resp_valid_o,
   input  logic                 resp_ready_i,
   output logic [TL_DW-1:0]     resp_rdata_o,
   output logic                 resp_error_o,

   tl_memory_master_bridge_if.master_ul tilelink
);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_SEND_A = 3'd1,
      ST_WAIT_D = 3'd2,
      ST_RESP   = 3'd3,
      ST_DRAIN  = 3'd4
   } state_e;

   typedef struct packed {
      logic               we;
      logic [TL_AW-1:0]   addr;
      mem_access_size_t   size;
      logic [TL_DW-1:0]   wdata;
   } req_t;

   localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CNT_W:0]        TIMEOUT_L = (CNT_W + 1)'(TIMEOUT);
   localparam logic [TL_SRCW-1:0]    SRC_ID    = TL_SRCW'(SOURCE_ID);

   state_e              state_q, state_d;
   req_t                req_q, req_d;
   logic [TL_DW-1:0]    rdata_q, rdata_d;
   logic                error_q, error_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                d_seen_q, d_seen_d;        // DRAIN: late D beat swallowed
   logic                resp_done_q, resp_done_d;  // DRAIN: error response taken

   logic [CNT_W:0]      cnt_inc;
   logic                timeout_hit;
   logic [2:0]          exp_d_opcode;
   logic                a_valid_c;
   logic                d_ready_c;

   logic [TL_DBW-1:0]   lane_mask;
   logic [TL_DW-1:0]    lane_wdata;
   logic [TL_DW-1:0]    lane_rdata;

   // Channel A fields derive only from the latched request, so they cannot
   // move while a_valid waits for a_ready.
   tl_lane_align u_lane_align (
      .size_i    (req_q.size),
      .addr_lo_i (req_q.addr[1:0]),
      .wdata_i   (req_q.wdata),
      .d_data_i  (tilelink.d_data),
      .a_mask_o  (lane_mask),
      .a_data_o  (lane_wdata),
      .rdata_o   (lane_rdata)
   );

   assign tilelink.a_valid   = a_valid_c;
   assign tilelink.a_opcode  = req_q.we ? TL_A_PUT_FULL_DATA : TL_A_GET;
   assign tilelink.a_param   = 3'd0;
   assign tilelink.a_size    = req_q.size;
   assign tilelink.a_source  = SRC_ID;
   assign tilelink.a_address = req_q.addr;
   assign tilelink.a_mask    = lane_mask;
   assign tilelink.a_data    = lane_wdata;
   assign tilelink.d_ready   = d_ready_c;

   assign resp_rdata_o = rdata_q;
   assign resp_error_o = error_q;

   assign exp_d_opcode = req_q.we ? TL_D_ACCESS_ACK : TL_D_ACCESS_ACK_DATA;
   assign cnt_inc      = {1'b0, cnt_q} + 1'b1;
   assign timeout_hit  = (TIMEOUT != 0) && (cnt_inc == TIMEOUT_L);

   always_comb begin
      state_d      = state_q;
      req_d        = req_q;
      rdata_d      = rdata_q;
      error_d      = error_q;
      cnt_d        = cnt_q;
      d_seen_d     = d_seen_q;
      resp_done_d  = resp_done_q;
      req_ready_o  = 1'b0;
      resp_valid_o = 1'b0;
      a_valid_c    = 1'b0;
      d_ready_c    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            req_ready_o = 1'b1;
            if (req_valid_i) begin
               req_d.we    = req_we_i;
               req_d.addr  = req_addr_i;
               req_d.size  = req_size_i;
               req_d.wdata = req_wdata_i;
               rdata_d     = '0;
               error_d     = 1'b0;
               // Misaligned accesses are answered locally, never issued.
               if (tl_is_misaligned(req_size_i, req_addr_i[1:0])) begin
                  error_d = 1'b1;
                  state_d = ST_RESP;
               end else begin
                  state_d = ST_SEND_A;
               end
            end
         end

         ST_SEND_A: begin
            a_valid_c = 1'b1;
            if (tilelink.a_ready) begin
               cnt_d   = '0;
               state_d = ST_WAIT_D;
            end
         end

         ST_WAIT_D: begin
            d_ready_c = 1'b1;
            if (tilelink.d_valid) begin
               rdata_d = req_q.we ? '0 : lane_rdata;
               error_d = tilelink.d_error
                       | (tilelink.d_source != SRC_ID)
                       | (tilelink.d_opcode != exp_d_opcode);
               state_d = ST_RESP;
            end else begin
               cnt_d = cnt_inc[CNT_W-1:0];
               if (timeout_hit) begin
                  error_d     = 1'b1;
                  d_seen_d    = 1'b0;
                  resp_done_d = 1'b0;
                  state_d     = ST_DRAIN;
               end
            end
         end

         ST_RESP: begin
            resp_valid_o = 1'b1;
            if (resp_ready_i) begin
               state_d = ST_IDLE;
            end
         end

         ST_DRAIN: begin
            // The transaction is still outstanding on the bus: keep the
            // error response up and swallow the late beat, in either order.
            d_ready_c    = !d_seen_q;
            resp_valid_o = !resp_done_q;
            if (tilelink.d_valid && !d_seen_q) begin
               d_seen_d = 1'b1;
            end
            if (resp_ready_i && !resp_done_q) begin
               resp_done_d = 1'b1;
            end
            if (d_seen_d && resp_done_d) begin
               state_d = ST_IDLE;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state_q     <= ST_IDLE;
         req_q       <= '0;
         rdata_q     <= '0;
         error_q     <= 1'b0;
         cnt_q       <= '0;
         d_seen_q    <= 1'b0;
         resp_done_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         req_q       <= req_d;
         rdata_q     <= rdata_d;
         error_q     <= error_d;
         cnt_q       <= cnt_d;
         d_seen_q    <= d_seen_d;
         resp_done_q <= resp_done_d;
      end
   end

endmodule

// File: tb/tb_tl_memory_master_bridge.sv
module tb_tl_memory_master_bridge import tl_memory_master_bridge_pkg::*; ();

   logic               clk = 1'b0;
   logic               reset_n;
   logic               req_valid;
   logic               req_ready;
   logic               req_we;
   logic [31:0]        req_addr;
   mem_access_size_t   req_size;
   logic [31:0]        req_wdata;
   logic               resp_valid;
   logic               resp_ready;
   logic [31:0]        resp_rdata;
   logic               resp_error;

   int n_cmp  = 0;
   int n_fail = 0;

   tl_memory_master_bridge_if tl_bus ();

   tl_memory_master_bridge #(
      .SOURCE_ID (0),
      .TIMEOUT   (8)
   ) dut (
      .clk_i        (clk),
      .reset_ni     (reset_n),
      .req_valid_i  (req_valid),
      .req_ready_o  (req_ready),
      .req_we_i     (req_we),
      .req_addr_i   (req_addr),
      .req_size_i   (req_size),
      .req_wdata_i  (req_wdata),
      .resp_valid_o (resp_valid),
      .resp_ready_i (resp_ready),
      .resp_rdata_o (resp_rdata),
      .resp_error_o (resp_error),
      .tilelink     (tl_bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      string            name;
      logic             we;
      logic [31:0]      addr;
      mem_access_size_t size;
      logic [31:0]      wdata;
      int               a_wait;     // cycles a_ready held low
      int               d_wait;     // WAIT_D cycles before d_valid
      int               r_wait;     // cycles resp_ready held low
      logic [2:0]       d_opcode;
      logic [3:0]       d_source;
      logic             d_error;
      logic [31:0]      d_data;
      logic             issue;      // expect a channel A request at all
      logic [2:0]       exp_opcode;
      logic [3:0]       exp_mask;
      logic [31:0]      exp_adata;
      logic [31:0]      exp_rdata;
      logic             exp_err;
   } vec_t;

   vec_t vecs[11];

   function automatic vec_t mk(string name, logic we, logic [31:0] addr,
                               mem_access_size_t size, logic [31:0] wdata,
                               int aw, int dw, int rw,
                               logic [2:0] dop, logic [3:0] dsrc, logic derr,
                               logic [31:0] ddata, logic issue, logic [2:0] eop,
                               logic [3:0] emask, logic [31:0] eadata,
                               logic [31:0] erdata, logic eerr);
      vec_t v;
      v.name = name; v.we = we; v.addr = addr; v.size = size; v.wdata = wdata;
      v.a_wait = aw; v.d_wait = dw; v.r_wait = rw;
      v.d_opcode = dop; v.d_source = dsrc; v.d_error = derr; v.d_data = ddata;
      v.issue = issue; v.exp_opcode = eop; v.exp_mask = emask;
      v.exp_adata = eadata; v.exp_rdata = erdata; v.exp_err = eerr;
      return v;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, required 0x%08h", nm, act, exp);
      end
   endtask

   task automatic chk_a(input vec_t v);
      chk({v.name, ":a_opcode"},  32'(tl_bus.a_opcode),  32'(v.exp_opcode));
      chk({v.name, ":a_mask"},    32'(tl_bus.a_mask),    32'(v.exp_mask));
      chk({v.name, ":a_data"},    tl_bus.a_data,         v.exp_adata);
      chk({v.name, ":a_size"},    32'(tl_bus.a_size),    32'(v.size));
      chk({v.name, ":a_address"}, tl_bus.a_address,      v.addr);
      chk({v.name, ":a_param"},   32'(tl_bus.a_param),   32'd0);
      chk({v.name, ":a_source"},  32'(tl_bus.a_source),  32'd0);
   endtask

   task automatic accept_resp(input string nm);
      resp_ready = 1'b1;
      step();
      resp_ready = 1'b0;
      chk({nm, ":resp_valid_after"}, 32'(resp_valid), 32'd0);
      chk({nm, ":req_ready_after"},  32'(req_ready),  32'd1);
   endtask

   task automatic run_vec(input int idx, input vec_t v);
      chk({v.name, ":req_ready"}, 32'(req_ready), 32'd1);
      req_valid = 1'b1;
      req_we    = v.we;
      req_addr  = v.addr;
      req_size  = v.size;
      req_wdata = v.wdata;
      step();
      req_valid = 1'b0;
      if (v.issue) begin
         chk({v.name, ":a_valid"}, 32'(tl_bus.a_valid), 32'd1);
         chk({v.name, ":resp_idle"}, 32'(resp_valid), 32'd0);
         chk_a(v);
         for (int i = 0; i < v.a_wait; i++) begin
            step();
            chk({v.name, ":a_valid_hold"}, 32'(tl_bus.a_valid), 32'd1);
            chk_a(v);
         end
         tl_bus.a_ready = 1'b1;
         step();
         tl_bus.a_ready = 1'b0;
         chk({v.name, ":a_valid_drop"}, 32'(tl_bus.a_valid), 32'd0);
         chk({v.name, ":d_ready"},      32'(tl_bus.d_ready), 32'd1);
         for (int i = 0; i < v.d_wait; i++) begin
            step();
            chk({v.name, ":wait_no_resp"}, 32'(resp_valid),     32'd0);
            chk({v.name, ":wait_d_ready"}, 32'(tl_bus.d_ready), 32'd1);
         end
         tl_bus.d_valid  = 1'b1;
         tl_bus.d_opcode = v.d_opcode;
         tl_bus.d_source = v.d_source;
         tl_bus.d_error  = v.d_error;
         tl_bus.d_data   = v.d_data;
         step();
         tl_bus.d_valid  = 1'b0;
         tl_bus.d_data   = 32'h0;
      end
      chk({v.name, ":resp_valid"}, 32'(resp_valid),     32'd1);
      chk({v.name, ":resp_rdata"}, resp_rdata,          v.exp_rdata);
      chk({v.name, ":resp_error"}, 32'(resp_error),     32'(v.exp_err));
      chk({v.name, ":a_quiet"},    32'(tl_bus.a_valid), 32'd0);
      chk({v.name, ":d_ready_off"}, 32'(tl_bus.d_ready), 32'd0);
      chk({v.name, ":req_busy"},   32'(req_ready),      32'd0);
      for (int i = 0; i < v.r_wait; i++) begin
         step();
         chk({v.name, ":resp_hold"},  32'(resp_valid), 32'd1);
         chk({v.name, ":rdata_hold"}, resp_rdata,      v.exp_rdata);
         chk({v.name, ":err_hold"},   32'(resp_error), 32'(v.exp_err));
         chk({v.name, ":a_hold_off"}, 32'(tl_bus.a_valid), 32'd0);
      end
      accept_resp(v.name);
      $display("txn %0d %-14s addr=0x%08h rdata=0x%08h err=%0d", idx, v.name,
               v.addr, resp_rdata, resp_error);
   endtask

   initial begin
      //           name            we  addr          size      wdata         aw dw rw dop   src derr ddata         iss eop   mask     adata         rdata         err
      vecs[0]  = mk("lw_aligned",   0, 32'h100, MEM_WORD, 32'h0,        0, 0, 0, 3'd1, 0, 0, 32'hDEADBEEF, 1, 3'd4, 4'b1111, 32'h0,        32'hDEADBEEF, 0);
      vecs[1]  = mk("sb_lane3",     1, 32'h103, MEM_BYTE, 32'h000000AB, 0, 0, 0, 3'd0, 0, 0, 32'h0,        1, 3'd0, 4'b1000, 32'hAB000000, 32'h0,        0);
      vecs[2]  = mk("lh_upper",     0, 32'h202, MEM_HALF, 32'h0,        0, 0, 0, 3'd1, 0, 0, 32'h12345678, 1, 3'd4, 4'b1100, 32'h0,        32'h00001234, 0);
      vecs[3]  = mk("lh_misalign",  0, 32'h201, MEM_HALF, 32'h0,        0, 0, 0, 3'd1, 0, 0, 32'h0,        0, 3'd0, 4'b0000, 32'h0,        32'h0,        1);
      vecs[4]  = mk("lw_stalls",    0, 32'h104, MEM_WORD, 32'h0,        5, 3, 4, 3'd1, 0, 0, 32'hCAFEF00D, 1, 3'd4, 4'b1111, 32'h0,        32'hCAFEF00D, 0);
      vecs[5]  = mk("lw_bad_src",   0, 32'h108, MEM_WORD, 32'h0,        0, 0, 0, 3'd1, 1, 0, 32'h0,        1, 3'd4, 4'b1111, 32'h0,        32'h0,        1);
      vecs[6]  = mk("sw_d_error",   1, 32'h10C, MEM_WORD, 32'h55667788, 0, 1, 0, 3'd0, 0, 1, 32'h0,        1, 3'd0, 4'b1111, 32'h55667788, 32'h0,        1);
      vecs[7]  = mk("lb_lane2",     0, 32'h002, MEM_BYTE, 32'h0,        0, 0, 1, 3'd1, 0, 0, 32'hAABBCCDD, 1, 3'd4, 4'b0100, 32'h0,        32'h000000BB, 0);
      vecs[8]  = mk("lw_bad_op",    0, 32'h110, MEM_WORD, 32'h0,        0, 0, 0, 3'd0, 0, 0, 32'h0,        1, 3'd4, 4'b1111, 32'h0,        32'h0,        1);
      vecs[9]  = mk("sw_misalign",  1, 32'h102, MEM_WORD, 32'h12345678, 0, 0, 0, 3'd0, 0, 0, 32'h0,        0, 3'd0, 4'b0000, 32'h0,        32'h0,        1);
      vecs[10] = mk("sh_lane2",     1, 32'h006, MEM_HALF, 32'h0000BEEF, 1, 0, 0, 3'd0, 0, 0, 32'h0,        1, 3'd0, 4'b1100, 32'hBEEF0000, 32'h0,        0);

      reset_n    = 1'b0;
      req_valid  = 1'b0;
      req_we     = 1'b0;
      req_addr   = 32'h0;
      req_size   = MEM_BYTE;
      req_wdata  = 32'h0;
      resp_ready = 1'b0;
      tl_bus.a_ready  = 1'b0;
      tl_bus.d_valid  = 1'b0;
      tl_bus.d_opcode = 3'd0;
      tl_bus.d_source = 4'd0;
      tl_bus.d_data   = 32'h0;
      tl_bus.d_error  = 1'b0;

      step();
      step();
      chk("reset:req_ready",  32'(req_ready),      32'd1);
      chk("reset:resp_valid", 32'(resp_valid),     32'd0);
      chk("reset:a_valid",    32'(tl_bus.a_valid), 32'd0);
      chk("reset:d_ready",    32'(tl_bus.d_ready), 32'd0);
      chk("reset:rdata",      resp_rdata,          32'd0);
      chk("reset:error",      32'(resp_error),     32'd0);
      reset_n = 1'b1;
      step();

      for (int i = 0; i < 11; i++) begin
         run_vec(i, vecs[i]);
      end

      // Timeout: no D beat for 8 WAIT_D cycles, then a late beat in DRAIN.
      req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h300; req_size = MEM_WORD;
      step();
      req_valid = 1'b0;
      chk("to:a_valid", 32'(tl_bus.a_valid), 32'd1);
      tl_bus.a_ready = 1'b1;
      step();
      tl_bus.a_ready = 1'b0;
      for (int i = 0; i < 8; i++) begin
         chk("to:wait_no_resp", 32'(resp_valid),     32'd0);
         chk("to:wait_d_ready", 32'(tl_bus.d_ready), 32'd1);
         step();
      end
      chk("to:resp_valid", 32'(resp_valid),     32'd1);
      chk("to:resp_error", 32'(resp_error),     32'd1);
      chk("to:rdata",      resp_rdata,          32'd0);
      chk("to:drain_dry",  32'(tl_bus.d_ready), 32'd1);
      resp_ready = 1'b1;
      step();
      resp_ready = 1'b0;
      chk("to:resp_taken",  32'(resp_valid),     32'd0);
      chk("to:still_busy",  32'(req_ready),      32'd0);
      chk("to:still_drain", 32'(tl_bus.d_ready), 32'd1);
      step();
      tl_bus.d_valid = 1'b1; tl_bus.d_opcode = 3'd1; tl_bus.d_data = 32'h77777777;
      step();
      tl_bus.d_valid = 1'b0;
      chk("to:idle_again", 32'(req_ready),  32'd1);
      for (int i = 0; i < 3; i++) begin
         chk("to:no_second_resp", 32'(resp_valid), 32'd0);
         step();
      end
      $display("txn 11 %-14s addr=0x%08h timeout path", "lw_timeout", 32'h300);

      // Asynchronous reset in WAIT_D, checked before any clock edge.
      req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h400; req_size = MEM_WORD;
      step();
      req_valid = 1'b0;
      tl_bus.a_ready = 1'b1;
      step();
      tl_bus.a_ready = 1'b0;
      chk("rst:pre_d_ready", 32'(tl_bus.d_ready), 32'd1);
      chk("rst:pre_busy",    32'(req_ready),      32'd0);
      reset_n = 1'b0;
      #1;
      chk("rst:d_ready",    32'(tl_bus.d_ready), 32'd0);
      chk("rst:a_valid",    32'(tl_bus.a_valid), 32'd0);
      chk("rst:resp_valid", 32'(resp_valid),     32'd0);
      chk("rst:req_ready",  32'(req_ready),      32'd1);
      chk("rst:rdata",      resp_rdata,          32'd0);
      chk("rst:error",      32'(resp_error),     32'd0);
      $display("txn 12 %-14s addr=0x%08h reset mid-flight", "lw_reset", 32'h400);
      step();
      reset_n = 1'b1;
      step();
      run_vec(13, vecs[0]);
      run_vec(14, vecs[5]);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
